mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-client (icache/dcache) arbiter in front of a single-outstanding main-memory port.
// Icache has default priority; a saturating wait counter lets a starving dcache win.
module mem_arbiter #(
    parameter int BLK_ADDR_W   = 29,
    parameter int BLOCK_W      = 64,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_aL,
    input  logic                  icache_req_valid,
    input  logic [BLK_ADDR_W-1:0] icache_req_block_addr,
    output logic                  icache_req_ready,
    input  logic                  icache_flush,
    output logic                  icache_resp_valid,
    output logic [BLOCK_W-1:0]    icache_resp_block_data,
    input  logic                  dcache_req_valid,
    input  logic                  dcache_req_type,
    input  logic [BLK_ADDR_W-1:0] dcache_req_block_addr,
    input  logic [BLOCK_W-1:0]    dcache_req_block_data,
    output logic                  dcache_req_ready,
    output logic                  dcache_resp_valid,
    output logic [BLOCK_W-1:0]    dcache_resp_block_data,
    output logic                  mem_req_valid,
    output logic                  mem_req_type,
    output logic [BLK_ADDR_W-1:0] mem_req_block_addr,
    output logic [BLOCK_W-1:0]    mem_req_block_data,
    input  logic                  mem_req_ready,
    input  logic                  mem_resp_valid,
    input  logic [BLOCK_W-1:0]    mem_resp_block_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIMIT);

    state_t                  state_r, state_nxt_s;
    logic                    owner_d_r;
    logic                    type_r;
    logic [BLK_ADDR_W-1:0]   addr_r;
    logic [BLOCK_W-1:0]      data_r;
    logic                    drop_r;
    logic [3:0]              starve_cnt_r;
    logic                    icache_resp_valid_r, dcache_resp_valid_r;
    logic [BLOCK_W-1:0]      icache_resp_data_r, dcache_resp_data_r;

    logic idle_s, ireq_live_s, starve_s, grant_d_s, grant_i_s;
    logic accept_s, resp_s, flush_hit_s, drop_now_s;

    assign idle_s      = (state_r == IDLE);
    assign ireq_live_s = icache_req_valid & ~icache_flush;
    assign starve_s    = (starve_cnt_r == STARVE_LIM_C);
    assign grant_d_s   = idle_s & dcache_req_valid & (starve_s | ~ireq_live_s);
    assign grant_i_s   = idle_s & ireq_live_s & ~grant_d_s;
    assign accept_s    = (state_r == ISSUE) & mem_req_ready;
    assign resp_s      = (state_r == WAIT_RESP) & mem_resp_valid;
    // A flush arriving together with the response still kills that response.
    assign flush_hit_s = ~owner_d_r & icache_flush & ((state_r == ISSUE) | (state_r == WAIT_RESP));
    assign drop_now_s  = drop_r | flush_hit_s;

    assign icache_req_ready       = grant_i_s;
    assign dcache_req_ready       = grant_d_s;
    assign mem_req_valid          = (state_r == ISSUE);
    assign mem_req_type           = type_r;
    assign mem_req_block_addr     = addr_r;
    assign mem_req_block_data     = data_r;
    assign busy                   = (state_r != IDLE);
    assign icache_resp_valid      = icache_resp_valid_r;
    assign icache_resp_block_data = icache_resp_data_r;
    assign dcache_resp_valid      = dcache_resp_valid_r;
    assign dcache_resp_block_data = dcache_resp_data_r;

    // Next-state logic for the single-transaction FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_d_s | grant_i_s) state_nxt_s = ISSUE;
                else                       state_nxt_s = IDLE;
            end
            ISSUE: begin
                if (mem_req_ready) state_nxt_s = type_r ? IDLE : WAIT_RESP;
                else               state_nxt_s = ISSUE;
            end
            WAIT_RESP: begin
                if (mem_resp_valid) state_nxt_s = IDLE;
                else                state_nxt_s = WAIT_RESP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, latched request fields, starvation counter, drop flag and response registers.
    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            state_r             <= IDLE;
            owner_d_r           <= 1'b0;
            type_r              <= 1'b0;
            addr_r              <= {BLK_ADDR_W{1'b0}};
            data_r              <= {BLOCK_W{1'b0}};
            drop_r              <= 1'b0;
            starve_cnt_r        <= 4'd0;
            icache_resp_valid_r <= 1'b0;
            dcache_resp_valid_r <= 1'b0;
            icache_resp_data_r  <= {BLOCK_W{1'b0}};
            dcache_resp_data_r  <= {BLOCK_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;

            if (grant_d_s) begin
                owner_d_r <= 1'b1;
                type_r    <= dcache_req_type;
                addr_r    <= dcache_req_block_addr;
                data_r    <= dcache_req_block_data;
            end else if (grant_i_s) begin
                owner_d_r <= 1'b0;
                type_r    <= 1'b0;
                addr_r    <= icache_req_block_addr;
                data_r    <= {BLOCK_W{1'b0}};
            end

            if (state_nxt_s == IDLE) drop_r <= 1'b0;
            else if (flush_hit_s)    drop_r <= 1'b1;

            if (dcache_req_valid & ~grant_d_s) begin
                if (!starve_s) starve_cnt_r <= starve_cnt_r + 4'd1;
            end else begin
                starve_cnt_r <= 4'd0;
            end

            icache_resp_valid_r <= resp_s & ~owner_d_r & ~drop_now_s;
            if (resp_s & ~owner_d_r & ~drop_now_s) icache_resp_data_r <= mem_resp_block_data;

            dcache_resp_valid_r <= (resp_s & owner_d_r) | (accept_s & type_r);
            if (resp_s & owner_d_r)     dcache_resp_data_r <= mem_resp_block_data;
            else if (accept_s & type_r) dcache_resp_data_r <= {BLOCK_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model compared every cycle,
// plus hand-computed literal checks on the key scenarios.
module tb_mem_arbiter;

    localparam int AW           = 29;
    localparam int DW           = 64;
    localparam int STARVE_LIMIT = 8;

    logic          clk = 1'b0;
    logic          rst_aL;
    logic          icache_req_valid;
    logic [AW-1:0] icache_req_block_addr;
    logic          icache_req_ready;
    logic          icache_flush;
    logic          icache_resp_valid;
    logic [DW-1:0] icache_resp_block_data;
    logic          dcache_req_valid;
    logic          dcache_req_type;
    logic [AW-1:0] dcache_req_block_addr;
    logic [DW-1:0] dcache_req_block_data;
    logic          dcache_req_ready;
    logic          dcache_resp_valid;
    logic [DW-1:0] dcache_resp_block_data;
    logic          mem_req_valid;
    logic          mem_req_type;
    logic [AW-1:0] mem_req_block_addr;
    logic [DW-1:0] mem_req_block_data;
    logic          mem_req_ready;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_block_data;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.BLK_ADDR_W(AW), .BLOCK_W(DW), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst_aL(rst_aL),
        .icache_req_valid(icache_req_valid), .icache_req_block_addr(icache_req_block_addr),
        .icache_req_ready(icache_req_ready), .icache_flush(icache_flush),
        .icache_resp_valid(icache_resp_valid), .icache_resp_block_data(icache_resp_block_data),
        .dcache_req_valid(dcache_req_valid), .dcache_req_type(dcache_req_type),
        .dcache_req_block_addr(dcache_req_block_addr), .dcache_req_block_data(dcache_req_block_data),
        .dcache_req_ready(dcache_req_ready), .dcache_resp_valid(dcache_resp_valid),
        .dcache_resp_block_data(dcache_resp_block_data),
        .mem_req_valid(mem_req_valid), .mem_req_type(mem_req_type),
        .mem_req_block_addr(mem_req_block_addr), .mem_req_block_data(mem_req_block_data),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_block_data(mem_resp_block_data), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction record (active / sent-to-memory / owner / fields)
    logic          m_active, m_sent, m_owner_d, m_write, m_drop;
    logic          m_ipulse, m_dpulse;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data, m_idata, m_ddata;
    int            m_wait;
    logic          m_gd, m_gi, m_drop_now;

    always_comb begin
        m_gd = 1'b0;
        m_gi = 1'b0;
        if (!m_active) begin
            // dcache wins when it has waited long enough or icache is not bidding
            m_gd = dcache_req_valid && ((m_wait == STARVE_LIMIT) || !(icache_req_valid && !icache_flush));
            m_gi = icache_req_valid && !icache_flush && !m_gd;
        end
        m_drop_now = m_drop || (m_active && !m_owner_d && icache_flush);
    end

    always @(posedge clk) begin
        if (!rst_aL) begin
            m_active <= 1'b0; m_sent <= 1'b0; m_owner_d <= 1'b0; m_write <= 1'b0; m_drop <= 1'b0;
            m_ipulse <= 1'b0; m_dpulse <= 1'b0; m_addr <= '0; m_data <= '0;
            m_idata <= '0; m_ddata <= '0; m_wait <= 0;
        end else begin
            m_ipulse <= 1'b0;
            m_dpulse <= 1'b0;
            if (dcache_req_valid && !m_gd) m_wait <= (m_wait < STARVE_LIMIT) ? m_wait + 1 : m_wait;
            else                           m_wait <= 0;
            if (!m_active) begin
                if (m_gd || m_gi) begin
                    m_active  <= 1'b1;
                    m_sent    <= 1'b0;
                    m_owner_d <= m_gd;
                    m_write   <= m_gd && dcache_req_type;
                    m_addr    <= m_gd ? dcache_req_block_addr : icache_req_block_addr;
                    m_data    <= m_gd ? dcache_req_block_data : 64'd0;
                end
            end else begin
                m_drop <= m_drop_now;
                if (!m_sent && mem_req_ready) begin
                    if (m_write) begin
                        m_active <= 1'b0; m_drop <= 1'b0; m_dpulse <= 1'b1; m_ddata <= 64'd0;
                    end else begin
                        m_sent <= 1'b1;
                    end
                end else if (m_sent && mem_resp_valid) begin
                    m_active <= 1'b0;
                    m_drop   <= 1'b0;
                    if (m_owner_d) begin
                        m_dpulse <= 1'b1; m_ddata <= mem_resp_block_data;
                    end else if (!m_drop_now) begin
                        m_ipulse <= 1'b1; m_idata <= mem_resp_block_data;
                    end
                end
            end
        end
    end

    // Compare every output against the model on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("icache_req_ready", 64'(icache_req_ready), 64'(m_gi));
            chk("dcache_req_ready", 64'(dcache_req_ready), 64'(m_gd));
            chk("mem_req_valid", 64'(mem_req_valid), 64'(m_active && !m_sent));
            chk("mem_req_type", 64'(mem_req_type), 64'(m_write));
            chk("mem_req_block_addr", 64'(mem_req_block_addr), 64'(m_addr));
            chk("mem_req_block_data", mem_req_block_data, m_data);
            chk("busy", 64'(busy), 64'(m_active));
            chk("icache_resp_valid", 64'(icache_resp_valid), 64'(m_ipulse));
            chk("dcache_resp_valid", 64'(dcache_resp_valid), 64'(m_dpulse));
            if (m_ipulse) chk("icache_resp_data", icache_resp_block_data, m_idata);
            if (m_dpulse) chk("dcache_resp_data", dcache_resp_block_data, m_ddata);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic icache_read(input logic [AW-1:0] a);
        icache_req_valid = 1'b1; icache_req_block_addr = a;
        cyc(); icache_req_valid = 1'b0; mem_req_ready = 1'b1;
        cyc(); mem_req_ready = 1'b0;
    endtask

    int found;

    initial begin
        rst_aL = 1'b0;
        icache_req_valid = 1'b0; icache_req_block_addr = '0; icache_flush = 1'b0;
        dcache_req_valid = 1'b0; dcache_req_type = 1'b0; dcache_req_block_addr = '0;
        dcache_req_block_data = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_resp_block_data = '0;
        cyc();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_addr", 64'(mem_req_block_addr), 64'd0);
        chk("rst_dresp_data", dcache_resp_block_data, 64'd0);
        cyc(); rst_aL = 1'b1;
        cyc();

        // Both request with counter 0: icache wins, then a 5-cycle read
        icache_req_valid = 1'b1; icache_req_block_addr = 29'h10;
        dcache_req_valid = 1'b1; dcache_req_block_addr = 29'h5;
        @(negedge clk);
        chk("both_icache_ready", 64'(icache_req_ready), 64'd1);
        chk("both_dcache_ready", 64'(dcache_req_ready), 64'd0);
        cyc(); icache_req_valid = 1'b0; dcache_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        chk("t1_mem_req_valid", 64'(mem_req_valid), 64'd1);
        chk("t1_mem_addr", 64'(mem_req_block_addr), 64'h10);
        chk("t1_mem_type", 64'(mem_req_type), 64'd0);
        cyc(); mem_req_ready = 1'b0;
        cyc();
        cyc(); mem_resp_valid = 1'b1; mem_resp_block_data = 64'hDEADBEEF_CAFEF00D;
        cyc(); mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("t5_icache_resp_valid", 64'(icache_resp_valid), 64'd1);
        chk("t5_icache_resp_data", icache_resp_block_data, 64'hDEADBEEF_CAFEF00D);
        chk("t5_busy", 64'(busy), 64'd0);

        // dcache write, memory stalls 3 cycles, inputs change meanwhile
        cyc(); dcache_req_valid = 1'b1; dcache_req_type = 1'b1;
        dcache_req_block_addr = 29'h3; dcache_req_block_data = 64'h1122334455667788;
        @(negedge clk);
        chk("wr_dcache_ready", 64'(dcache_req_ready), 64'd1);
        cyc(); dcache_req_valid = 1'b0; dcache_req_type = 1'b0;
        dcache_req_block_addr = 29'h1F; dcache_req_block_data = 64'hFFFF0000FFFF0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("wr_hold_valid", 64'(mem_req_valid), 64'd1);
            chk("wr_hold_addr", 64'(mem_req_block_addr), 64'h3);
            chk("wr_hold_data", mem_req_block_data, 64'h1122334455667788);
            chk("wr_hold_type", 64'(mem_req_type), 64'd1);
            cyc();
        end
        mem_req_ready = 1'b1;
        cyc(); mem_req_ready = 1'b0;
        @(negedge clk);
        chk("wr_ack_valid", 64'(dcache_resp_valid), 64'd1);
        chk("wr_ack_data", dcache_resp_block_data, 64'd0);
        chk("wr_ack_busy", 64'(busy), 64'd0);

        // dcache read ignoring flush, with icache granted in the response cycle
        cyc(); dcache_req_valid = 1'b1; dcache_req_block_addr = 29'h7;
        cyc(); dcache_req_valid = 1'b0; mem_req_ready = 1'b1;
        cyc(); mem_req_ready = 1'b0; icache_flush = 1'b1;
        cyc(); icache_flush = 1'b0; mem_resp_valid = 1'b1; mem_resp_block_data = 64'h0123456789ABCDEF;
        cyc(); mem_resp_valid = 1'b0; icache_req_valid = 1'b1; icache_req_block_addr = 29'h20;
        @(negedge clk);
        chk("rd_dresp_valid", 64'(dcache_resp_valid), 64'd1);
        chk("rd_dresp_data", dcache_resp_block_data, 64'h0123456789ABCDEF);
        chk("turnaround_icache_ready", 64'(icache_req_ready), 64'd1);

        // Flush while the icache fill waits: fill discarded
        cyc(); icache_req_valid = 1'b0; mem_req_ready = 1'b1;
        cyc(); mem_req_ready = 1'b0; icache_flush = 1'b1;
        cyc(); icache_flush = 1'b0; mem_resp_valid = 1'b1; mem_resp_block_data = 64'hAAAA5555AAAA5555;
        cyc(); mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("flush_no_resp", 64'(icache_resp_valid), 64'd0);
        chk("flush_idle", 64'(busy), 64'd0);

        // Flush in the same cycle as the response
        cyc(); icache_read(29'h30);
        mem_resp_valid = 1'b1; icache_flush = 1'b1; mem_resp_block_data = 64'h1234;
        cyc(); mem_resp_valid = 1'b0; icache_flush = 1'b0;
        @(negedge clk);
        chk("flush_same_cycle", 64'(icache_resp_valid), 64'd0);

        // Drop flag must not leak into the next fill
        cyc(); icache_read(29'h31);
        mem_resp_valid = 1'b1; mem_resp_block_data = 64'h77;
        cyc(); mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("after_drop_valid", 64'(icache_resp_valid), 64'd1);
        chk("after_drop_data", icache_resp_block_data, 64'h77);

        // Starvation: both held, memory always ready/responding; dcache wins at cycle 9
        cyc();
        icache_req_valid = 1'b1; icache_req_block_addr = 29'h40;
        dcache_req_valid = 1'b1; dcache_req_block_addr = 29'h44;
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_block_data = 64'h5555AAAA5555AAAA;
        found = -1;
        for (int k = 0; k < 40 && found < 0; k++) begin
            @(negedge clk);
            if (dcache_req_ready) found = k;
            cyc();
        end
        chk("starve_grant_cycle", 64'(found), 64'd9);
        icache_req_valid = 1'b0; dcache_req_valid = 1'b0;
        cyc(); cyc(); cyc();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        cyc();

        // Reset during WAIT_RESP, late response afterwards must vanish
        icache_read(29'h50);
        rst_aL = 1'b0;
        cyc(); rst_aL = 1'b1; mem_resp_valid = 1'b1; mem_resp_block_data = 64'h99;
        cyc(); mem_resp_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_iresp", 64'(icache_resp_valid), 64'd0);
        chk("rst_mid_dresp", 64'(dcache_resp_valid), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_mem_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_mid_addr", 64'(mem_req_block_addr), 64'd0);
        chk("rst_mid_iresp_data", icache_resp_block_data, 64'd0);
        cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
